// File: rtl/dma_pkg.sv
// Shared constants and FSM states for the mem2strm read-address engine.
package dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_64    = 3'b011;
  localparam int         PAGE_WORDS     = 512;
  localparam int         MAX_BURST      = 16;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ADDR,
    WAIT_DATA
  } state_t;

endpackage

// File: rtl/dma_burst_len.sv
// Burst sizing: smallest of configured burst, words left to request,
// and words left before the next 4 KB page boundary.
module dma_burst_len
  import dma_pkg::*;
#(
  parameter int LengthBits = 16
) (
  input  logic [4:0]            burst_cfg,
  input  logic [LengthBits-1:0] issue_left,
  input  logic [8:0]            page_off,
  output logic [4:0]            n
);

  logic [9:0] page_left;
  logic [4:0] m;

  always_comb begin
    page_left = 10'(PAGE_WORDS) - {1'b0, page_off};
    m = burst_cfg;
    if (issue_left < LengthBits'(m))
      m = issue_left[4:0];
    if (page_left < {5'd0, m})
      m = page_left[4:0];
    n = m;
  end

endmodule

// File: rtl/dma_rd_addr_gen.sv
// Read-side DMA core: splits a transfer into AXI INCR AR bursts under
// FIFO credit and tracks returning beats for done/remain/err status.
module dma_rd_addr_gen
  import dma_pkg::*;
#(
  parameter int AddrBits     = 32,
  parameter int LengthBits   = 16,
  parameter int BurstBits    = 5,
  parameter int FifoUsedBits = 7,
  parameter int FifoDepth    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AddrBits-1:0]     dma_start,
  input  logic [LengthBits-1:0]   dma_len,
  input  logic [BurstBits-1:0]    dma_burst,
  input  logic                    dma_valid,
  output logic                    dma_done,
  output logic [LengthBits-1:0]   dma_remain,
  output logic [LengthBits-1:0]   dma_curr_len,
  output logic [1:0]              dma_err,
  input  logic [FifoUsedBits-1:0] fifo_used,
  output logic [AddrBits-1:0]     m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic                    rd_beat,
  input  logic [1:0]              rd_resp
);

  localparam int CW = LengthBits + 2;

  state_t                state, state_d;
  logic [AddrBits-1:0]   addr;
  logic [LengthBits-1:0] issue_left;
  logic [LengthBits-1:0] beat_left;
  logic [LengthBits-1:0] outstanding;
  logic [LengthBits-1:0] out_d;
  logic [4:0]            burst_cfg;
  logic [4:0]            burst_cl;
  logic [4:0]            n;
  logic [4:0]            n_ar;
  logic [CW-1:0]         need;
  logic                  start;
  logic                  credit_ok;
  logic                  ar_fire;
  logic                  beat_ok;
  logic                  last_beat;

  dma_burst_len #(
    .LengthBits(LengthBits)
  ) u_burst_len (
    .burst_cfg (burst_cfg),
    .issue_left(issue_left),
    .page_off  (addr[11:3]),
    .n         (n)
  );

  assign m_arsize   = AXI_SIZE_64;
  assign m_arburst  = AXI_BURST_INCR;
  assign dma_remain = beat_left;
  assign n_ar       = m_arlen[4:0] + 5'd1;
  assign need       = CW'(fifo_used) + CW'(outstanding) + CW'(n);
  assign credit_ok  = need <= CW'(FifoDepth);
  assign beat_ok    = (state != IDLE) && rd_beat
                   && (beat_left != '0);

  always_comb begin
    burst_cl = 5'(dma_burst);
    unique case (1'b1)
      (dma_burst == '0):             burst_cl = 5'd1;
      (int'(dma_burst) > MAX_BURST): burst_cl = 5'(MAX_BURST);
      default:                       burst_cl = 5'(dma_burst);
    endcase
  end

  always_comb begin
    state_d   = state;
    start     = 1'b0;
    ar_fire   = 1'b0;
    last_beat = 1'b0;
    unique case (state)
      IDLE: begin
        // config buffer swaps on the done edge; wait it out
        if (dma_valid && !dma_done) begin
          start = 1'b1;
          if (dma_len != '0)
            state_d = CALC;
        end
      end
      CALC: begin
        if (credit_ok)
          state_d = ADDR;
      end
      ADDR: begin
        if (m_arready) begin
          ar_fire = 1'b1;
          if (issue_left == LengthBits'(n_ar))
            state_d = WAIT_DATA;
          else
            state_d = CALC;
        end
      end
      WAIT_DATA: state_d = WAIT_DATA;
      default:   state_d = IDLE;
    endcase
    if (beat_ok && beat_left == LengthBits'(1)) begin
      last_beat = 1'b1;
      state_d   = IDLE;
    end
  end

  always_comb begin
    out_d = outstanding;
    if (ar_fire)
      out_d = out_d + LengthBits'(n_ar);
    if (beat_ok && (ar_fire || outstanding != '0))
      out_d = out_d - LengthBits'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr         <= '0;
      issue_left   <= '0;
      beat_left    <= '0;
      outstanding  <= '0;
      burst_cfg    <= 5'd1;
      dma_done     <= 1'b0;
      dma_curr_len <= '0;
      dma_err      <= 2'b00;
      m_araddr     <= '0;
      m_arlen      <= '0;
      m_arvalid    <= 1'b0;
    end else begin
      dma_done    <= last_beat || (start && dma_len == '0);
      dma_err     <= (rd_beat && rd_resp != 2'b00) ? rd_resp : 2'b00;
      outstanding <= out_d;
      if (beat_ok)
        beat_left <= beat_left - LengthBits'(1);
      if (start) begin
        addr         <= {dma_start[AddrBits-1:3], 3'b000};
        issue_left   <= dma_len;
        beat_left    <= dma_len;
        dma_curr_len <= dma_len;
        burst_cfg    <= burst_cl;
        outstanding  <= '0;
      end
      if (state == CALC && credit_ok) begin
        m_araddr  <= addr;
        m_arlen   <= {3'b000, n - 5'd1};
        m_arvalid <= 1'b1;
      end
      if (ar_fire) begin
        m_arvalid  <= 1'b0;
        addr       <= addr + AddrBits'({n_ar, 3'b000});
        issue_left <= issue_left - LengthBits'(n_ar);
      end
      if (last_beat)
        m_arvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_rd_addr_gen.sv
// Bench for dma_rd_addr_gen: vector table, hand sequences, and random
// transfers checked against a transfer-level burst model.
module tb_dma_rd_addr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dma_start;
  logic [15:0] dma_len;
  logic [4:0]  dma_burst;
  logic        dma_valid;
  logic        dma_done;
  logic [15:0] dma_remain;
  logic [15:0] dma_curr_len;
  logic [1:0]  dma_err;
  logic [6:0]  fifo_used;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        m_arready;
  logic        rd_beat;
  logic [1:0]  rd_resp;

  int errors = 0;
  int checks = 0;

  dma_rd_addr_gen dut (
    .clk         (clk),
    .rst         (rst),
    .dma_start   (dma_start),
    .dma_len     (dma_len),
    .dma_burst   (dma_burst),
    .dma_valid   (dma_valid),
    .dma_done    (dma_done),
    .dma_remain  (dma_remain),
    .dma_curr_len(dma_curr_len),
    .dma_err     (dma_err),
    .fifo_used   (fifo_used),
    .m_araddr    (m_araddr),
    .m_arlen     (m_arlen),
    .m_arsize    (m_arsize),
    .m_arburst   (m_arburst),
    .m_arvalid   (m_arvalid),
    .m_arready   (m_arready),
    .rd_beat     (rd_beat),
    .rd_resp     (rd_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  l;
  } ar_t;

  typedef struct {
    logic [31:0] st;
    logic [15:0] ln;
    logic [4:0]  bu;
    int          eb;
    int          nar;
    logic [31:0] a0;
    logic [7:0]  l0;
    logic [31:0] a1;
    logic [7:0]  l1;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_arvalid(input int lim);
    int k = 0;
    while (!m_arvalid && k < lim) begin
      tick();
      k++;
    end
  endtask

  task automatic run_xfer(input logic [31:0] st, input logic [15:0] ln,
                          input logic [4:0] bu, input bit rnd,
                          input int err_beat, output int n_ar,
                          output logic [31:0] a0, output logic [7:0] l0,
                          output logic [31:0] a1, output logic [7:0] l1);
    ar_t         exp_q[$];
    ar_t         e;
    logic [31:0] a;
    int          left, b, pg, nw;
    int          pool = 0, got = 0, cyc = 0;
    bit          done_seen = 0;
    logic        pv, prdy, pbeat;
    logic [31:0] pa;
    logic [7:0]  pl;
    logic [1:0]  presp;
    int          pfu, ppool;
    n_ar = 0; a0 = '0; l0 = '0; a1 = '0; l1 = '0;
    a    = st & ~32'h7;
    left = int'(ln);
    b    = (bu == 0) ? 1 : ((bu > 16) ? 16 : int'(bu));
    while (left > 0) begin
      pg = 512 - int'((a >> 3) & 32'h1ff);
      nw = b;
      if (left < nw) nw = left;
      if (pg < nw) nw = pg;
      exp_q.push_back('{a, 8'(nw - 1)});
      a    = a + 32'(nw * 8);
      left = left - nw;
    end
    dma_start = st; dma_len = ln; dma_burst = bu; dma_valid = 1'b1;
    while (!done_seen && cyc < 1500) begin
      m_arready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      fifo_used = rnd ? 7'($urandom_range(0, 63)) : 7'd0;
      rd_beat   = (pool > 0) && (!rnd || $urandom_range(0, 2) != 0);
      rd_resp   = rnd ? 2'($urandom_range(0, 3)) : 2'b00;
      if (rd_beat && got == err_beat) rd_resp = 2'b10;
      pv = m_arvalid; pa = m_araddr; pl = m_arlen;
      prdy = m_arready; pbeat = rd_beat; presp = rd_resp;
      pfu = int'(fifo_used); ppool = pool;
      tick();
      cyc++;
      if (pv && prdy) begin
        if (exp_q.size() == 0) begin
          chk("ar_extra", 64'(n_ar + 1), 64'(n_ar));
        end else begin
          e = exp_q.pop_front();
          chk("ar_addr", 64'(pa), 64'(e.a));
          chk("ar_len", 64'(pl), 64'(e.l));
        end
        if (n_ar == 0) begin a0 = pa; l0 = pl; end
        a1 = pa; l1 = pl;
        n_ar++;
        pool += int'(pl) + 1;
      end
      if (pbeat) begin
        pool--;
        got++;
      end
      chk("err", 64'(dma_err),
          64'((pbeat && presp != 2'b00) ? presp : 2'b00));
      chk("remain", 64'(dma_remain), 64'(int'(ln) - got));
      chk("done", 64'(dma_done), 64'(pbeat && got == int'(ln)));
      if (m_arvalid && !pv)
        chk("credit", 64'(pfu + ppool + int'(m_arlen) + 1 <= 64), 64'(1));
      if (pv && !prdy)
        chk("ar_hold", {m_arvalid, m_araddr, m_arlen},
            {1'b1, pa, pl});
      if (got == int'(ln)) done_seen = 1;
    end
    if (!done_seen)
      chk("xfer_timeout", 64'(got), 64'(ln));
    chk("ar_missing", 64'(exp_q.size()), 64'(0));
    chk("curr_len", 64'(dma_curr_len), 64'(ln));
    dma_valid = 1'b0; rd_beat = 1'b0; m_arready = 1'b0; fifo_used = '0;
    tick();
    chk("done_width", 64'(dma_done), 64'(0));
  endtask

  vec_t        tbl[8];
  int          nar;
  logic [31:0] a0, a1;
  logic [7:0]  l0, l1;
  logic [31:0] rs;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h1000, 16'd32, 5'd16, -1, 2, 32'h1000, 8'd15, 32'h1080, 8'd15};
    tbl[1] = '{32'h0FF0, 16'd8, 5'd16, -1, 2, 32'h0FF0, 8'd1, 32'h1000, 8'd5};
    tbl[2] = '{32'h0000, 16'd20, 5'd16, -1, 2, 32'h0000, 8'd15, 32'h0080, 8'd3};
    tbl[3] = '{32'h0000, 16'd20, 5'd0, -1, 20, 32'h0000, 8'd0, 32'h0098, 8'd0};
    tbl[4] = '{32'h0000, 16'd20, 5'd31, -1, 2, 32'h0000, 8'd15, 32'h0080, 8'd3};
    tbl[5] = '{32'h0FF8, 16'd4, 5'd16, -1, 2, 32'h0FF8, 8'd0, 32'h1000, 8'd2};
    tbl[6] = '{32'hFFFFFFF0, 16'd4, 5'd16, -1, 2, 32'hFFFFFFF0, 8'd1, 32'h0, 8'd1};
    tbl[7] = '{32'h4005, 16'd4, 5'd4, 2, 1, 32'h4000, 8'd3, 32'h4000, 8'd3};

    rst = 1'b1; dma_start = '0; dma_len = '0; dma_burst = '0;
    dma_valid = 1'b0; fifo_used = '0; m_arready = 1'b0;
    rd_beat = 1'b0; rd_resp = 2'b00;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_done", 64'(dma_done), 64'(0));
    chk("rst_remain", 64'(dma_remain), 64'(0));
    chk("rst_curr_len", 64'(dma_curr_len), 64'(0));
    chk("rst_err", 64'(dma_err), 64'(0));
    chk("rst_ar", {m_arvalid, m_araddr, m_arlen}, 64'(0));
    chk("arsize", 64'(m_arsize), 64'(3));
    chk("arburst", 64'(m_arburst), 64'(1));

    for (int i = 0; i < 8; i++) begin
      run_xfer(tbl[i].st, tbl[i].ln, tbl[i].bu, 1'b0, tbl[i].eb,
               nar, a0, l0, a1, l1);
      chk($sformatf("tbl%0d_nar", i), 64'(nar), 64'(tbl[i].nar));
      chk($sformatf("tbl%0d_first", i), {a0, l0}, {tbl[i].a0, tbl[i].l0});
      chk($sformatf("tbl%0d_last", i), {a1, l1}, {tbl[i].a1, tbl[i].l1});
    end

    // FIFO credit gating, then AR held under arready backpressure
    dma_start = 32'h3000; dma_len = 16'd8; dma_burst = 5'd8;
    fifo_used = 7'd60; dma_valid = 1'b1;
    nar = 0;
    repeat (10) begin
      tick();
      if (m_arvalid) nar++;
    end
    chk("credit_block", 64'(nar), 64'(0));
    fifo_used = 7'd48;
    wait_arvalid(5);
    chk("credit_go", {m_arvalid, m_araddr, m_arlen}, {1'b1, 32'h3000, 8'd7});
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {m_arvalid, m_araddr, m_arlen}, {1'b1, 32'h3000, 8'd7});
    end
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    chk("bp_drop", 64'(m_arvalid), 64'(0));
    rd_beat = 1'b1;
    repeat (8) tick();
    rd_beat = 1'b0;
    chk("bp_done", {dma_done, dma_remain}, {1'b1, 16'd0});
    dma_valid = 1'b0; fifo_used = '0;
    tick();
    chk("bp_done_width", 64'(dma_done), 64'(0));

    // zero-length config, then the next config starts after the pulse
    dma_start = 32'h6000; dma_len = 16'd0; dma_burst = 5'd4; dma_valid = 1'b1;
    tick();
    chk("zero_done", {dma_done, m_arvalid}, {1'b1, 1'b0});
    dma_start = 32'h2000; dma_len = 16'd4;
    tick();
    chk("zero_pulse", {dma_done, m_arvalid}, {1'b0, 1'b0});
    wait_arvalid(5);
    chk("zero_next_ar", {m_arvalid, m_araddr, m_arlen}, {1'b1, 32'h2000, 8'd3});
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    rd_beat = 1'b1;
    repeat (4) tick();
    rd_beat = 1'b0;
    chk("zero_next_done", {dma_done, dma_remain, dma_curr_len},
        {1'b1, 16'd0, 16'd4});
    dma_valid = 1'b0;
    tick();

    // reset while an AR is pending
    dma_start = 32'h5000; dma_len = 16'd8; dma_burst = 5'd8; dma_valid = 1'b1;
    wait_arvalid(5);
    chk("rst_pre_ar", 64'(m_arvalid), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0; dma_valid = 1'b0;
    chk("rst_mid", {m_arvalid, dma_remain, dma_curr_len, dma_done},
        {1'b0, 16'd0, 16'd0, 1'b0});
    repeat (3) tick();
    chk("rst_idle", 64'(m_arvalid), 64'(0));

    // stray beats in IDLE must not disturb any counter
    rd_beat = 1'b1;
    repeat (3) tick();
    rd_beat = 1'b0;
    tick();
    chk("idle_beats", {dma_remain, dma_done}, {16'd0, 1'b0});
    run_xfer(32'h7000, 16'd40, 5'd16, 1'b0, -1, nar, a0, l0, a1, l1);
    chk("post_idle_nar", 64'(nar), 64'(3));

    for (int i = 0; i < 20; i++) begin
      rs = $urandom;
      if ($urandom_range(0, 1) == 1)
        rs[11:0] = 12'(12'hF80 + $urandom_range(0, 127));
      run_xfer(rs, 16'($urandom_range(1, 80)), 5'($urandom_range(0, 31)),
               1'b1, -1, nar, a0, l0, a1, l1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
